// File: rtl/iosram_agu_port.sv
// Self-decoding IO-SRAM access port: decodes DSU/REP/REPX for its own port ID and
// walks a nested-loop address sequence, realigning read data to the SRAM latency.
module iosram_agu_port #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 256,
  parameter int NUM_LEVELS   = 4,
  parameter int PORT_ID      = 0,
  parameter int READ_LATENCY = 1,
  parameter int INSTR_WIDTH  = 27
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_en,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   activate,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  output logic                   sram_en_o,
  output logic                   sram_we_o,
  output logic [ADDR_WIDTH-1:0]  sram_addr_o,
  output logic [DATA_WIDTH-1:0]  sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]  sram_rdata_i,
  output logic                   rd_valid_o,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam logic [2:0] OP_REP  = 3'd0;
  localparam logic [2:0] OP_REPX = 3'd1;
  localparam logic [2:0] OP_DSU  = 3'd6;
  localparam logic [1:0] MY_PORT = 2'(PORT_ID);

  typedef enum logic [1:0] {IDLE, RUN, DELAY} state_t;

  state_t                  state;
  logic [2:0]              opcode;
  logic [23:0]             payload;
  logic                    dsu_hit, rep_hit, repx_hit, lvl_hit, lvl_bad, busy;

  logic [11:0]             iter_q  [NUM_LEVELS];
  logic [11:0]             step_q  [NUM_LEVELS];
  logic [11:0]             delay_q [NUM_LEVELS];
  logic [NUM_LEVELS-1:0]   loaded_q;
  logic [ADDR_WIDTH-1:0]   init_q, init_n;
  logic                    dir_q, dir_n, err_q;

  logic [11:0]             idx_q   [NUM_LEVELS];
  logic [11:0]             idx_adv [NUM_LEVELS];
  logic [11:0]             dcnt_q, adv_delay;
  logic [ADDR_WIDTH-1:0]   addr_adv;
  logic                    last, carry, at_max;

  logic                    rd_now;
  logic [READ_LATENCY-1:0] rd_sr;
  logic [READ_LATENCY:0]   rd_vec;

  assign opcode  = instr[INSTR_WIDTH-1 -: 3];
  assign payload = instr[23:0];
  assign busy    = (state != IDLE);
  assign busy_o  = busy;
  assign err_o   = err_q;

  always_comb begin
    dsu_hit  = instr_en && (opcode == OP_DSU)  && (payload[6:5]   == MY_PORT);
    rep_hit  = instr_en && (opcode == OP_REP)  && (payload[23:22] == MY_PORT);
    repx_hit = instr_en && (opcode == OP_REPX) && (payload[23:22] == MY_PORT);
    lvl_hit  = rep_hit || repx_hit;
    lvl_bad  = int'(payload[21:18]) >= NUM_LEVELS;
    // A DSU arriving together with activate must already steer the first access.
    init_n   = (dsu_hit && !busy) ? payload[7 +: ADDR_WIDTH] : init_q;
    dir_n    = (dsu_hit && !busy) ? payload[23] : dir_q;
  end

  // NOTE: the level config lives in plain flops, not a memory macro, so it can be
  // cleared by reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NUM_LEVELS; l++) begin
        iter_q[l]  <= '0;
        step_q[l]  <= '0;
        delay_q[l] <= '0;
      end
      loaded_q <= '0;
      init_q   <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if ((dsu_hit || lvl_hit) && busy) begin
        err_q <= 1'b1;
      end else begin
        if (dsu_hit) begin
          init_q   <= payload[7 +: ADDR_WIDTH];
          dir_q    <= payload[23];
          loaded_q <= '0;
        end
        if (lvl_hit && lvl_bad) err_q <= 1'b1;
        for (int l = 0; l < NUM_LEVELS; l++) begin
          if (lvl_hit && !lvl_bad && (payload[21:18] == 4'(l))) begin
            if (rep_hit) begin
              iter_q[l]   <= {6'd0, payload[17:12]};
              step_q[l]   <= {6'd0, payload[11:6]};
              delay_q[l]  <= {6'd0, payload[5:0]};
              loaded_q[l] <= 1'b1;
            end else begin
              iter_q[l][11:6]  <= payload[17:12];
              step_q[l][11:6]  <= payload[11:6];
              delay_q[l][11:6] <= payload[5:0];
            end
          end
        end
      end
      if (activate && busy) err_q <= 1'b1;
    end
  end

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    carry     = 1'b1;
    last      = 1'b1;
    at_max    = 1'b0;
    adv_delay = '0;
    addr_adv  = init_q;
    for (int l = 0; l < NUM_LEVELS; l++) begin
      idx_adv[l] = idx_q[l];
      at_max     = idx_q[l] == (loaded_q[l] ? iter_q[l] : 12'd0);
      if (!at_max) last = 1'b0;
      if (carry) begin
        if (at_max) begin
          idx_adv[l] = '0;
        end else begin
          idx_adv[l] = idx_q[l] + 12'd1;
          adv_delay  = delay_q[l];
          carry      = 1'b0;
        end
      end
      addr_adv = addr_adv + ADDR_WIDTH'(idx_adv[l]) * ADDR_WIDTH'(step_q[l]);
    end
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dcnt_q      <= '0;
      sram_en_o   <= 1'b0;
      sram_we_o   <= 1'b0;
      sram_addr_o <= '0;
      for (int l = 0; l < NUM_LEVELS; l++) idx_q[l] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (activate) begin
            state       <= RUN;
            sram_en_o   <= 1'b1;
            sram_we_o   <= dir_n;
            sram_addr_o <= init_n;
            for (int l = 0; l < NUM_LEVELS; l++) idx_q[l] <= '0;
          end
        end
        RUN: begin
          if (last) begin
            state     <= IDLE;
            sram_en_o <= 1'b0;
            sram_we_o <= 1'b0;
          end else begin
            for (int l = 0; l < NUM_LEVELS; l++) idx_q[l] <= idx_adv[l];
            sram_addr_o <= addr_adv;
            if (adv_delay != 12'd0) begin
              state     <= DELAY;
              dcnt_q    <= adv_delay;
              sram_en_o <= 1'b0;
              sram_we_o <= 1'b0;
            end
          end
        end
        DELAY: begin
          if (dcnt_q == 12'd1) begin
            state     <= RUN;
            sram_en_o <= 1'b1;
            sram_we_o <= dir_q;
          end else begin
            dcnt_q <= dcnt_q - 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sram_wdata_o = (sram_en_o && sram_we_o) ? wr_data_i : '0;

  // rd_vec[k] marks a read issued k cycles ago; data is captured one cycle before valid.
  assign rd_now     = sram_en_o && !sram_we_o;
  assign rd_vec     = {rd_sr, rd_now};
  assign rd_valid_o = rd_sr[READ_LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sr     <= '0;
      rd_data_o <= '0;
    end else begin
      rd_sr <= rd_vec[READ_LATENCY-1:0];
      if (rd_vec[READ_LATENCY-1]) rd_data_o <= sram_rdata_i;
    end
  end

endmodule

// File: doc/iosram_agu_port.md
Name: iosram_agu_port

Overview:
- Parametrised, self-decoding SRAM/IO access port: the next-generation replacement for the fixed per-port address generators in the IO-SRAM tiles.
- Decodes DSU/REP/REPX instructions addressed to its own port ID and runs an up-to-NUM_LEVELS nested-loop address sequence on activate.
- Drives SRAM enable, address and write-enable, and realigns read data to SRAM read latency with a matching valid.
- Adds REPX extended fields, per-level delay, runtime read/write direction, busy/error status and configurable address width, unlike the previous fixed-width ports.

Parameters:
- ADDR_WIDTH, 6: SRAM/IO address width, 1..16.
- DATA_WIDTH, 256: bulk data width.
- NUM_LEVELS, 4: loop levels, 1..16.
- PORT_ID, 0: 2-bit port number this instance answers to.
- READ_LATENCY, 1: SRAM read latency in cycles, 1..4.
- INSTR_WIDTH, 27: instruction width; top 3 bits are the opcode.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- instr_en  in  1  instruction valid.
- instr  in  INSTR_WIDTH  instruction.
- activate  in  1  start sequence.
- wr_data_i  in  DATA_WIDTH  write data, sampled on addressed write cycles.
- sram_en_o  out  1  SRAM access enable.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  ADDR_WIDTH  SRAM address.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_rdata_i  in  DATA_WIDTH  SRAM read data.
- rd_valid_o  out  1  read data valid.
- rd_data_o  out  DATA_WIDTH  aligned read data.
- busy_o  out  1  sequence in progress.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset:
  - All outputs 0.
  - Level configs cleared to unloaded.
  - init_addr = 0, dir = read, state IDLE.
  - Read pipeline flushed; err cleared.
  - Reset mid-sequence aborts the sequence immediately; no further SRAM accesses.
- Decode: payload = instr[23:0].
  - DSU (opcode 6): payload[22:7] init_addr, [6:5] port. Also payload[23] = direction, 1 = write.
  - REP (opcode 0): [23:22] port, [21:18] level, [17:12] iter, [11:6] step, [5:0] delay.
  - REPX (opcode 1): same layout as REP.
  - An instruction is accepted only when instr_en = 1 and its port field equals PORT_ID. Other opcodes are ignored.
- Config registers, per level: iter, step and delay, each 12 bits, plus a loaded flag.
  - REP writes bits [5:0], clears bits [11:6] and sets loaded.
  - REPX writes bits [11:6] only.
  - A level index >= NUM_LEVELS sets err_o; config is unchanged.
  - DSU stores init_addr truncated to ADDR_WIDTH and the direction bit, and clears all loaded flags.
- Instructions accepted while busy_o = 1 are dropped and set err_o.
- FSM states: IDLE, RUN, DELAY.
  - IDLE→RUN on activate: busy_o = 1 from the next cycle. The first access is issued in that same next cycle.
  - RUN: one access per cycle. sram_en_o = 1; sram_we_o = dir; sram_wdata_o = wr_data_i when writing, otherwise 0.
  - Address = init + Σ idx_l·step_l, modulo 2^ADDR_WIDTH. Steps are unsigned; wrap-around is silent.
  - Index advance: level 0 is innermost. Counts are iter+1 for loaded levels and 1 for unloaded levels. A carry resets lower indices to 0.
  - After an access that advances level l (the highest level that incremented), go to DELAY for delay_l cycles; 0 means stay in RUN.
  - DELAY: no access issued. Return to RUN when the count expires.
  - Final access (all indices at their max) → IDLE; busy_o drops the cycle after.
  - With no levels loaded, exactly one access at init.
  - activate while busy is ignored and sets err_o. activate in the same cycle as an accepted instruction: the instruction takes effect first.
- Read path: for each read access, rd_valid_o = 1 exactly READ_LATENCY cycles later, with rd_data_o = sram_rdata_i registered in that cycle.
  - rd_data_o holds its value when rd_valid_o = 0.
  - Write accesses never produce rd_valid_o.
- err_o is sticky until rst.

Test Plan:
- Single read: DSU(init=5, read), activate, no REP → one access, addr 5 in the cycle after activate. With READ_LATENCY = 1, rd_valid_o is high 2 cycles after activate and rd_data_o equals the SRAM word at 5.
- Two-level: REP L0 iter=3 step=1; REP L1 iter=1 step=8; init=2 → addresses 2,3,4,5,10,11,12,13 on consecutive cycles, then busy_o falls.
- Delay and REPX: REP L0 iter=2 step=4 delay=2, then REPX L0 iter_hi=1 (count 67) → 2 idle cycles between accesses; the 67th access ends the sequence. With ADDR_WIDTH = 6, addresses wrap mod 64.
- Write: DSU dir=1 init=60, REP L0 iter=5 step=1 → sram_we_o = 1 at addresses 60,61,62,63,0,1; rd_valid_o stays 0.
- Errors: activate during RUN, and REP with level=9 when NUM_LEVELS = 4 → err_o = 1 and stays set; the running sequence is unchanged. Instruction with another port ID → no effect, err_o = 0.
- Reset mid-sequence: assert rst during RUN → all outputs 0 immediately. After release, activate with no new DSU → single access at addr 0.
